contador_param: RTL and testbench

//  Parametrised bank of per-channel occupancy counters: each channel counts up on push and down on pop.
//  A req/idx readout port returns one channel's count, registered, with a valid strobe.

---
 rtl/contador_param.sv | 202 ++++++++++++++++++++
 tb/tb_contador_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/contador_param.sv
// -----------------------------------------------------------------------------
// contador_param
//   Bank of NUM_CH per-channel occupancy counters. Each channel counts up on
//   push and down on pop. A push and a pop on the same channel in the same
//   cycle cancel out. Full/empty behaviour is either saturate or wrap, selected
//   by SAT_MODE. Sticky ovf/udf flags record every attempt to go past max or
//   below zero. A req/idx port returns one channel's count one cycle later,
//   together with a valid strobe. The read can optionally clear that channel
//   (CLR_ON_READ). idle reports that every counter was zero on the previous
//   cycle.
//
// Ports
//   clk      in   1        rising-edge clock
//   reset_L  in   1        asynchronous reset, active-low
//   push     in   NUM_CH   push[i]: one word entered channel i this cycle
//   pop      in   NUM_CH   pop[i]:  one word left channel i this cycle
//   req      in   1        readout request, sampled on the clk edge
//   idx      in   IDX_W    channel selected for readout
//   data     out  DATA_W   registered, zero-extended count of the read channel
//   valid    out  1        high for the cycle after each sampled req
//   ovf      out  NUM_CH   sticky overflow flag per channel
//   udf      out  NUM_CH   sticky underflow flag per channel
//   idle     out  1        registered: all counters were zero last cycle
// -----------------------------------------------------------------------------
module contador_param #(
  parameter int NUM_CH      = 5,
  parameter int CNT_W       = 4,
  parameter int IDX_W       = 3,
  parameter int DATA_W      = 6,
  parameter bit SAT_MODE    = 1'b1,
  parameter bit CLR_ON_READ = 1'b0
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [NUM_CH-1:0] push,
  input  logic [NUM_CH-1:0] pop,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [NUM_CH-1:0] ovf,
  output logic [NUM_CH-1:0] udf,
  output logic              idle
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // One extra bit so that NUM_CH == 2^IDX_W is still representable.
  localparam logic [IDX_W:0]   NUM_CH_W = (IDX_W + 1)'(NUM_CH);

  // Counter state and its combinational next value.
  logic [CNT_W-1:0]  cnt_r     [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt_s [NUM_CH];

  logic [NUM_CH-1:0] ovf_set_s;
  logic [NUM_CH-1:0] udf_set_s;
  logic [NUM_CH-1:0] clr_sel_s;

  logic              idx_ok_s;
  logic [CNT_W-1:0]  rd_cnt_s;
  logic              all_zero_s;

  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic [NUM_CH-1:0] ovf_r;
  logic [NUM_CH-1:0] udf_r;
  logic              idle_r;

  // Out-of-range indices read as zero and must never select a channel.
  assign idx_ok_s = ({1'b0, idx} < NUM_CH_W);

  // Readout mux: pre-update count of the addressed channel, zero if out of range.
  always_comb begin
    rd_cnt_s = CNT_ZERO;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_ok_s && (idx == IDX_W'(i))) begin
        rd_cnt_s = cnt_r[i];
      end else begin
        rd_cnt_s = rd_cnt_s;
      end
    end
  end

  // Clear-on-read selection: only the channel addressed by an accepted req.
  always_comb begin
    clr_sel_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (CLR_ON_READ && req && (idx == IDX_W'(i))) begin
        clr_sel_s[i] = 1'b1;
      end else begin
        clr_sel_s[i] = 1'b0;
      end
    end
  end

  // Per-channel next count and overflow/underflow detection.
  always_comb begin
    ovf_set_s = {NUM_CH{1'b0}};
    udf_set_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (clr_sel_s[i]) begin
        // A read that clears the channel still accounts for a word arriving in
        // that same cycle. A pop is dropped, since the channel is being
        // emptied anyway.
        if (push[i] && !pop[i]) begin
          cnt_nxt_s[i] = CNT_ONE;
        end else begin
          cnt_nxt_s[i] = CNT_ZERO;
        end
      end else begin
        case ({push[i], pop[i]})
          2'b10: begin
            if (cnt_r[i] == CNT_MAX) begin
              ovf_set_s[i] = 1'b1;
              cnt_nxt_s[i] = SAT_MODE ? CNT_MAX : CNT_ZERO;
            end else begin
              cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
          end
          2'b01: begin
            if (cnt_r[i] == CNT_ZERO) begin
              udf_set_s[i] = 1'b1;
              cnt_nxt_s[i] = SAT_MODE ? CNT_ZERO : CNT_MAX;
            end else begin
              cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            end
          end
          // Both or neither: the occupancy is unchanged, even at the limits.
          default: cnt_nxt_s[i] = cnt_r[i];
        endcase
      end
    end
  end

  // All-zero detect on the current (already updated) counter state.
  always_comb begin
    all_zero_s = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_r[i] != CNT_ZERO) begin
        all_zero_s = 1'b0;
      end else begin
        all_zero_s = all_zero_s;
      end
    end
  end

  // Counter bank: every channel updates in parallel on each edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Sticky error flags: once set they stay set until reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ovf_r <= {NUM_CH{1'b0}};
      udf_r <= {NUM_CH{1'b0}};
    end else begin
      ovf_r <= ovf_r | ovf_set_s;
      udf_r <= udf_r | udf_set_s;
    end
  end

  // Readout register: data follows a sampled req and holds otherwise.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_r  <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
    end else if (req) begin
      data_r  <= DATA_W'(rd_cnt_s);
      valid_r <= 1'b1;
    end else begin
      data_r  <= data_r;
      valid_r <= 1'b0;
    end
  end

  // Idle register: set one cycle after the last counter has reached zero.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      idle_r <= 1'b1;
    end else begin
      idle_r <= all_zero_s;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;
  assign ovf   = ovf_r;
  assign udf   = udf_r;
  assign idle  = idle_r;

endmodule

// File: tb/tb_contador_param.sv
// Three instances share one stimulus: saturating (0), wrapping (1) and
// saturating with clear-on-read (2). A behavioural model tracks each instance
// and is compared every cycle; literal expectations pin the directed scenarios.
module tb_contador_param;

  localparam int NCH = 5;
  localparam int CW  = 4;
  localparam int IW  = 3;
  localparam int DW  = 6;
  localparam int MAXV = (1 << CW) - 1;

  logic           clk;
  logic           reset_L;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic           req;
  logic [IW-1:0]  idx;

  logic [DW-1:0]  data_w  [3];
  logic           valid_w [3];
  logic [NCH-1:0] ovf_w   [3];
  logic [NCH-1:0] udf_w   [3];
  logic           idle_w  [3];

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state
  bit sat_of [3] = '{1'b1, 1'b0, 1'b1};
  bit clr_of [3] = '{1'b0, 1'b0, 1'b1};
  int m_cnt  [3][NCH];
  int m_ovf  [3];
  int m_udf  [3];
  int m_data [3];
  int m_valid[3];
  int m_idle [3];

  contador_param #(.NUM_CH(NCH), .CNT_W(CW), .IDX_W(IW), .DATA_W(DW),
                   .SAT_MODE(1'b1), .CLR_ON_READ(1'b0)) u_sat (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .req(req), .idx(idx),
    .data(data_w[0]), .valid(valid_w[0]), .ovf(ovf_w[0]), .udf(udf_w[0]), .idle(idle_w[0]));

  contador_param #(.NUM_CH(NCH), .CNT_W(CW), .IDX_W(IW), .DATA_W(DW),
                   .SAT_MODE(1'b0), .CLR_ON_READ(1'b0)) u_wrap (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .req(req), .idx(idx),
    .data(data_w[1]), .valid(valid_w[1]), .ovf(ovf_w[1]), .udf(udf_w[1]), .idle(idle_w[1]));

  contador_param #(.NUM_CH(NCH), .CNT_W(CW), .IDX_W(IW), .DATA_W(DW),
                   .SAT_MODE(1'b1), .CLR_ON_READ(1'b1)) u_clr (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .req(req), .idx(idx),
    .data(data_w[2]), .valid(valid_w[2]), .ovf(ovf_w[2]), .udf(udf_w[2]), .idle(idle_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0d expected %0d", name, k, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NCH; c++) m_cnt[k][c] = 0;
      m_ovf[k] = 0; m_udf[k] = 0; m_data[k] = 0; m_valid[k] = 0; m_idle[k] = 1;
    end
  endtask

  // One clock edge of the specification's rules, applied to every instance.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit all_zero;
      all_zero = 1'b1;
      for (int c = 0; c < NCH; c++) if (m_cnt[k][c] != 0) all_zero = 1'b0;
      m_idle[k] = all_zero ? 1 : 0;
      if (req) begin
        m_valid[k] = 1;
        m_data[k]  = (int'(idx) < NCH) ? m_cnt[k][int'(idx)] : 0;
      end else begin
        m_valid[k] = 0;
      end
      for (int c = 0; c < NCH; c++) begin
        bit p, q;
        p = push[c];
        q = pop[c];
        if (clr_of[k] && req && int'(idx) == c) begin
          m_cnt[k][c] = (p && !q) ? 1 : 0;
        end else if (p && !q) begin
          if (m_cnt[k][c] == MAXV) begin
            m_ovf[k] |= (1 << c);
            m_cnt[k][c] = sat_of[k] ? MAXV : 0;
          end else m_cnt[k][c] += 1;
        end else if (q && !p) begin
          if (m_cnt[k][c] == 0) begin
            m_udf[k] |= (1 << c);
            m_cnt[k][c] = sat_of[k] ? 0 : MAXV;
          end else m_cnt[k][c] -= 1;
        end
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 3; k++) begin
      chk("data",  k, int'(data_w[k]),  m_data[k]);
      chk("valid", k, int'(valid_w[k]), m_valid[k]);
      chk("ovf",   k, int'(ovf_w[k]),   m_ovf[k]);
      chk("udf",   k, int'(udf_w[k]),   m_udf[k]);
      chk("idle",  k, int'(idle_w[k]),  m_idle[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input logic [NCH-1:0] p, input logic [NCH-1:0] q,
                       input logic r, input int i);
    push = p; pop = q; req = r; idx = IW'(i);
  endtask

  // Asserts reset between edges and checks outputs respond without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_data",  k, int'(data_w[k]),  0);
      chk("rst_valid", k, int'(valid_w[k]), 0);
      chk("rst_ovf",   k, int'(ovf_w[k]),   0);
      chk("rst_udf",   k, int'(udf_w[k]),   0);
      chk("rst_idle",  k, int'(idle_w[k]),  1);
    end
    drive('0, '0, 1'b0, 0);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b1;
    drive('0, '0, 1'b0, 0);
    model_reset();
    do_reset();

    // Two counts read back to back
    drive(5'b10001, '0, 1'b0, 0); tick();
    drive(5'b00001, '0, 1'b0, 0); tick(); tick();
    drive('0, '0, 1'b1, 0); tick();
    chk("t2_data0",  0, int'(data_w[0]), 3);
    chk("t2_valid0", 0, int'(valid_w[0]), 1);
    drive('0, '0, 1'b1, 4); tick();
    chk("t2_data4",  0, int'(data_w[0]), 1);
    chk("t2_valid4", 0, int'(valid_w[0]), 1);
    drive('0, '0, 1'b0, 0); tick();
    chk("t2_vdrop", 0, int'(valid_w[0]), 0);
    chk("t2_hold",  0, int'(data_w[0]), 1);

    // Saturation on ch2
    do_reset();
    drive(5'b00100, '0, 1'b0, 0);
    for (int n = 0; n < 17; n++) tick();
    drive('0, '0, 1'b1, 2); tick();
    chk("t3_max", 0, int'(data_w[0]), 15);
    chk("t3_ovf", 0, int'(ovf_w[0][2]), 1);
    chk("t3_wrapcnt", 1, int'(data_w[1]), 1);
    drive('0, 5'b00100, 1'b0, 0);
    for (int n = 0; n < 16; n++) tick();
    drive('0, '0, 1'b1, 2); tick();
    chk("t3_zero", 0, int'(data_w[0]), 0);
    chk("t3_udf",  0, int'(udf_w[0][2]), 1);

    // Wrap on ch1
    do_reset();
    drive(5'b00010, '0, 1'b0, 0);
    for (int n = 0; n < 16; n++) tick();
    drive('0, '0, 1'b1, 1); tick();
    chk("t4_wrap0", 1, int'(data_w[1]), 0);
    chk("t4_ovf",   1, int'(ovf_w[1][1]), 1);
    drive('0, 5'b00010, 1'b0, 0); tick();
    drive('0, '0, 1'b1, 1); tick();
    chk("t4_wrap15", 1, int'(data_w[1]), 15);
    chk("t4_udf",    1, int'(udf_w[1][1]), 1);

    // Simultaneous push/pop holds; out-of-range read
    do_reset();
    drive(5'b00010, '0, 1'b0, 0);
    for (int n = 0; n < 7; n++) tick();
    drive(5'b00010, 5'b00010, 1'b0, 0); tick();
    drive('0, '0, 1'b1, 1); tick();
    chk("t5_hold", 0, int'(data_w[0]), 7);
    drive('0, '0, 1'b1, 6); tick();
    chk("t5_oor_data",  0, int'(data_w[0]), 0);
    chk("t5_oor_valid", 0, int'(valid_w[0]), 1);

    // Clear-on-read and idle lag
    do_reset();
    drive(5'b01000, '0, 1'b0, 0);
    for (int n = 0; n < 5; n++) tick();
    drive(5'b01000, '0, 1'b1, 3); tick();
    chk("t6_pre", 2, int'(data_w[2]), 5);
    drive('0, '0, 1'b1, 3); tick();
    chk("t6_one",  2, int'(data_w[2]), 1);
    chk("t6_busy", 2, int'(idle_w[2]), 0);
    drive('0, '0, 1'b0, 0); tick();
    chk("t6_idle", 2, int'(idle_w[2]), 1);

    // Randomized: push-heavy, then reset mid-operation, then mixed traffic
    do_reset();
    for (int n = 0; n < 150; n++) begin
      logic [NCH-1:0] a, b;
      a = NCH'($urandom); b = NCH'($urandom);
      drive(a | b, a & b, 1'($urandom), int'($urandom_range(0, 7)));
      tick();
    end
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [NCH-1:0] a, b;
      a = NCH'($urandom); b = NCH'($urandom);
      if (n < 150) drive(a, b, 1'($urandom), int'($urandom_range(0, 7)));
      else drive(a & b, a | b, 1'($urandom), int'($urandom_range(0, 7)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
